// File: rtl/delay_line_ctrl.sv
// delay_line_ctrl: sequences a dual-port block RAM as a circular audio delay line.
// Optional feature macro DELAY_FEEDBACK_EN mixes the scaled wet sample back into the written data.
module delay_line_ctrl #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [ADDR_WIDTH-1:0] delay,
  input  logic [7:0]            fb_gain,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  ram_ena,
  output logic                  ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dia,
  output logic                  ram_enb,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [DATA_WIDTH-1:0] ram_dob
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, OUT} state_t;

  localparam logic [ADDR_WIDTH-1:0] DMAX    = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                state, state_n;
  logic                  in_ready_n, out_valid_n, ram_ena_n, ram_wea_n, ram_enb_n;
  logic [DATA_WIDTH-1:0] out_data_n, ram_dia_n;
  logic [ADDR_WIDTH-1:0] ram_addra_n, ram_addrb_n;
  logic [DATA_WIDTH-1:0] data_q, data_n, dly_q, dly_n;
  logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_n, fill_cnt, fill_cnt_n, d_q, d_n;
  logic [ADDR_WIDTH-1:0] d_eff, rd_addr;
  logic [DATA_WIDTH-1:0] dly_now, wdata;

  // Clamp the requested delay into 1..DEPTH-1 and find the matching read slot behind wr_ptr.
  always_comb begin
    d_eff = delay;
    if (delay == '0)
      d_eff = ADDR_WIDTH'(1);
    else if (delay > DMAX)
      d_eff = DMAX;
    if (wr_ptr >= d_eff)
      rd_addr = wr_ptr - d_eff;
    else
      rd_addr = ADDR_WIDTH'(DEPTH_W + {1'b0, wr_ptr} - {1'b0, d_eff});
    dly_now = (fill_cnt < d_q) ? '0 : ram_dob;
  end

`ifdef DELAY_FEEDBACK_EN
  logic signed [DATA_WIDTH+8:0] fb_prod;
  logic signed [DATA_WIDTH+9:0] fb_sum;

  // Saturate whenever the sum's upper bits are not all copies of the sign bit.
  always_comb begin
    fb_prod = (DATA_WIDTH + 9)'($signed(dly_now)) * (DATA_WIDTH + 9)'($signed({1'b0, fb_gain}));
    fb_sum  = (DATA_WIDTH + 10)'($signed(data_q)) + (DATA_WIDTH + 10)'(fb_prod >>> 8);
    if (!(&fb_sum[DATA_WIDTH+9:DATA_WIDTH-1]) && (|fb_sum[DATA_WIDTH+9:DATA_WIDTH-1]))
      wdata = fb_sum[DATA_WIDTH+9] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else
      wdata = fb_sum[DATA_WIDTH-1:0];
  end
`else
  logic unused_fb_gain;
  assign unused_fb_gain = ^fb_gain;
  assign wdata = data_q;
`endif

  always_comb begin
    state_n     = state;
    in_ready_n  = in_ready;
    out_valid_n = out_valid;
    out_data_n  = out_data;
    ram_ena_n   = ram_ena;
    ram_wea_n   = ram_wea;
    ram_addra_n = ram_addra;
    ram_dia_n   = ram_dia;
    ram_enb_n   = ram_enb;
    ram_addrb_n = ram_addrb;
    data_n      = data_q;
    dly_n       = dly_q;
    wr_ptr_n    = wr_ptr;
    fill_cnt_n  = fill_cnt;
    d_n         = d_q;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          data_n      = in_data;
          d_n         = d_eff;
          ram_enb_n   = 1'b1;
          ram_addrb_n = rd_addr;
          in_ready_n  = 1'b0;
          state_n     = RD;
        end
      end
      RD: begin
        ram_enb_n = 1'b0;
        state_n   = CAP;
      end
      CAP: begin
        dly_n       = dly_now;
        ram_ena_n   = 1'b1;
        ram_wea_n   = 1'b1;
        ram_addra_n = wr_ptr;
        ram_dia_n   = wdata;
        state_n     = WR;
      end
      WR: begin
        ram_ena_n   = 1'b0;
        ram_wea_n   = 1'b0;
        wr_ptr_n    = (wr_ptr == DMAX) ? '0 : wr_ptr + ADDR_WIDTH'(1);
        fill_cnt_n  = (fill_cnt == DMAX) ? fill_cnt : fill_cnt + ADDR_WIDTH'(1);
        out_data_n  = dly_q;
        out_valid_n = 1'b1;
        state_n     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          in_ready_n  = 1'b1;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Every output is a flop; a reset drops any write still in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      ram_ena   <= 1'b0;
      ram_wea   <= 1'b0;
      ram_addra <= '0;
      ram_dia   <= '0;
      ram_enb   <= 1'b0;
      ram_addrb <= '0;
      data_q    <= '0;
      dly_q     <= '0;
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      d_q       <= '0;
    end else begin
      state     <= state_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
      ram_ena   <= ram_ena_n;
      ram_wea   <= ram_wea_n;
      ram_addra <= ram_addra_n;
      ram_dia   <= ram_dia_n;
      ram_enb   <= ram_enb_n;
      ram_addrb <= ram_addrb_n;
      data_q    <= data_n;
      dly_q     <= dly_n;
      wr_ptr    <= wr_ptr_n;
      fill_cnt  <= fill_cnt_n;
      d_q       <= d_n;
    end
  end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// tb_delay_line_ctrl: drives delay_line_ctrl against a RAM model and a sample-history reference.
// Honours DELAY_FEEDBACK_EN the same way as the design.
module tb_delay_line_ctrl;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DW    = 24;

  logic          clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic          in_ready, out_valid, ram_ena, ram_wea, ram_enb;
  logic [DW-1:0] in_data = '0, out_data, ram_dia, ram_dob;
  logic [AW-1:0] delay = '0, ram_addra, ram_addrb;
  logic [7:0]    fb_gain = '0;

  int vectors = 0, miscompares = 0, cyc = 0, acc_cyc = 0, rdy_mode = 0, fail_prints = 0;
  bit busy = 1'b0;
  logic [DW-1:0] hist[$], got_q[$], dia_q[$];
  logic [AW-1:0] wa_q[$];
  int            acc_q[$];
  logic [DW-1:0] exp_out, exp_dia;
  int            exp_rd, exp_wa;
  logic [DW-1:0] mem [DEPTH];

  delay_line_ctrl #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .delay(delay), .fb_gain(fb_gain), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra),
    .ram_dia(ram_dia), .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_dob(ram_dob)
  );

  always #5 clk = ~clk;

  // Block RAM stand-in, preloaded with garbage so priming leaks would show.
  initial for (int i = 0; i < DEPTH; i++) mem[i] <= DW'($urandom);
  always @(posedge clk) begin
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dia;
    if (ram_enb) ram_dob <= mem[ram_addrb];
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 2) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (fail_prints < 40) begin
        fail_prints++;
        $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
    end
  endtask

`ifdef DELAY_FEEDBACK_EN
  function automatic logic [DW-1:0] fbModel(input logic [DW-1:0] din, input logic [DW-1:0] dly,
                                            input logic [7:0] g);
    longint s;
    s = longint'($signed(din)) + ((longint'($signed(dly)) * longint'(g)) >>> 8);
    if (s > 64'sd8388607)  s = 64'sd8388607;
    if (s < -64'sd8388608) s = -64'sd8388608;
    return s[DW-1:0];
  endfunction
`endif

  // Reference: output n equals the word written d samples earlier, or 0 if fewer than d exist.
  always @(negedge clk) begin
    int since, n, d;
    if (reset) begin
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_data", 32'(out_data), 32'd0);
      checkOutput("rst_ram_ctl", 32'({ram_ena, ram_wea, ram_enb}), 32'd0);
      checkOutput("rst_ram_addr", 32'({ram_addra, ram_addrb}), 32'd0);
      checkOutput("rst_ram_dia", 32'(ram_dia), 32'd0);
      hist.delete();
      busy = 1'b0;
    end else if (busy) begin
      since = cyc - acc_cyc;
      checkOutput("busy_in_ready", 32'(in_ready), 32'd0);
      checkOutput("ram_enb", 32'(ram_enb), 32'(since == 1));
      if (since == 1) checkOutput("ram_addrb", 32'(ram_addrb), 32'(exp_rd));
      checkOutput("ram_ena", 32'(ram_ena), 32'(since == 3));
      checkOutput("ram_wea", 32'(ram_wea), 32'(since == 3));
      if (since == 3) begin
        checkOutput("ram_addra", 32'(ram_addra), 32'(exp_wa));
        checkOutput("ram_dia", 32'(ram_dia), 32'(exp_dia));
        wa_q.push_back(ram_addra);
        dia_q.push_back(ram_dia);
      end
      checkOutput("out_valid", 32'(out_valid), 32'(since >= 4));
      if (since >= 4) begin
        checkOutput("out_data", 32'(out_data), 32'(exp_out));
        if (out_ready) begin
          got_q.push_back(out_data);
          busy = 1'b0;
        end
      end
    end else begin
      checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
      checkOutput("idle_out_valid", 32'(out_valid), 32'd0);
      checkOutput("idle_ram_en", 32'({ram_ena, ram_enb}), 32'd0);
      if (in_valid) begin
        d = (delay == 0) ? 1 : int'(delay);
        if (d > DEPTH - 1) d = DEPTH - 1;
        n = hist.size();
        exp_rd  = ((n - d) % DEPTH + DEPTH) % DEPTH;
        exp_wa  = n % DEPTH;
        exp_out = (n < d) ? '0 : hist[n-d];
        exp_dia = in_data;
`ifdef DELAY_FEEDBACK_EN
        exp_dia = fbModel(in_data, exp_out, fb_gain);
`endif
        hist.push_back(exp_dia);
        acc_cyc = cyc;
        acc_q.push_back(cyc);
        busy = 1'b1;
      end
    end
    cyc++;
  end

  task automatic applyStimulus(input logic [DW-1:0] data, input logic [AW-1:0] dly, input logic [7:0] g);
    int k;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = data;
    delay    = dly;
    fb_gain  = g;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = DW'($urandom);
    delay    = AW'($urandom);
  endtask

  task automatic waitIdle();
    int k;
    k = 0;
    @(negedge clk);
    while (!(in_ready && !out_valid) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) checkOutput("idle_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    got_q.delete();
    acc_q.delete();
    wa_q.delete();
    dia_q.delete();
  endtask

  task automatic expectGot(input string name, input int idx, input logic [DW-1:0] exp);
    if (idx < got_q.size()) checkOutput(name, 32'(got_q[idx]), 32'(exp));
    else checkOutput({name, "_missing"}, 32'(got_q.size()), 32'(idx + 1));
  endtask

  initial begin
    logic [DW-1:0] exp2[6];
    logic [DW-1:0] exp4[3];
    logic [AW-1:0] cur_d;
    exp2 = '{24'd0, 24'd0, 24'd0, 24'd1, 24'd2, 24'd3};
    exp4 = '{24'd0, 24'd7, 24'd8};
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset during WR loses that sample; the next output is primed to 0.
    applyStimulus(24'h000123, 4'd1, 8'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    got_q.delete();
    applyStimulus(24'h000456, 4'd1, 8'd0);
    waitIdle();
    expectGot("post_reset_prime", 0, 24'd0);

    doReset();
    for (int i = 1; i <= 6; i++) applyStimulus(DW'(i), 4'd3, 8'd0);
    waitIdle();
    for (int i = 0; i < 6; i++) expectGot("delay3_seq", i, exp2[i]);
    for (int i = 1; i < 6 && i < acc_q.size(); i++)
      checkOutput("throughput", 32'(acc_q[i] - acc_q[i-1]), 32'd5);

    doReset();
    for (int k = 0; k < 40; k++) applyStimulus(DW'(k), 4'd15, 8'd0);
    waitIdle();
    for (int k = 0; k < 40; k++) expectGot("delay15_ramp", k, (k >= 15) ? DW'(k - 15) : '0);
    if (wa_q.size() > 16) begin
      checkOutput("addra_pre_wrap", 32'(wa_q[15]), 32'd15);
      checkOutput("addra_wrap", 32'(wa_q[16]), 32'd0);
    end else checkOutput("addra_count", 32'(wa_q.size()), 32'd40);

    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(DW'(7 + i), 4'd0, 8'd0);
    waitIdle();
    for (int i = 0; i < 3; i++) expectGot("delay0_seq", i, exp4[i]);

    // Backpressure: output held in OUT with out_ready low for well over 5 cycles.
    rdy_mode = 2;
    applyStimulus(24'h000055, 4'd1, 8'd0);
    repeat (12) @(negedge clk);
    checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_out_data", 32'(out_data), 32'd9);
    rdy_mode = 0;
    waitIdle();

`ifdef DELAY_FEEDBACK_EN
    doReset();
    applyStimulus(24'h100000, 4'd2, 8'd128);
    for (int i = 0; i < 6; i++) applyStimulus(24'h0, 4'd2, 8'd128);
    waitIdle();
    expectGot("fb_imp0", 0, 24'h0);
    expectGot("fb_imp2", 2, 24'h100000);
    expectGot("fb_imp3", 3, 24'h0);
    expectGot("fb_imp4", 4, 24'h080000);
    expectGot("fb_imp6", 6, 24'h040000);
    doReset();
    applyStimulus(24'h7FFFFF, 4'd1, 8'd255);
    applyStimulus(24'h7FFFFF, 4'd1, 8'd255);
    waitIdle();
    if (dia_q.size() > 1) checkOutput("fb_saturate", 32'(dia_q[1]), 32'h7FFFFF);
    else checkOutput("fb_sat_count", 32'(dia_q.size()), 32'd2);
`endif

    doReset();
    rdy_mode = 1;
    cur_d = AW'($urandom_range(0, 15));
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 3) == 0) cur_d = AW'($urandom_range(0, 15));
      if (i == 120) begin
        waitIdle();
        doReset();
      end
      applyStimulus(DW'($urandom), cur_d, 8'($urandom));
    end
    rdy_mode = 0;
    waitIdle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
